// File: rtl/serial_sub_ctrl_if.sv
// Start/done handshake bundle between an operand-issuing master and the
// bit-serial subtractor controller.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (output start, a, b, bin, input  busy, done, diff, bout);
    modport slave  (input  start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: runs one full-subtractor cell over WIDTH
// cycles, LSB first, keeping the borrow between bits in a register.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             cell_d;
    logic             cell_b;
    logic [WIDTH-1:0] sd_nxt;
    logic             last;

    // Full-subtractor cell; sd_nxt already holds the current bit in its MSB.
    assign cell_d = sa[0] ^ sb[0] ^ c;
    assign cell_b = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & c);
    assign sd_nxt = WIDTH'({cell_d, sd} >> 1);
    assign last   = (cnt == CW'(WIDTH - 1));

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        c   <= bus.bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    sd <= sd_nxt;
                    c  <= cell_b;
                    if (last) begin
                        diff_q <= sd_nxt;
                        bout_q <= cell_b;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags decode the state register only, so no input reaches an output combinationally.
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench: three instances (WIDTH 8, 1, 16) compared every cycle
// against a timeline/arithmetic model of the start/done protocol.
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(8))  if8 ();
    serial_sub_ctrl_if #(.WIDTH(1))  if1 ();
    serial_sub_ctrl_if #(.WIDTH(16)) if16 ();

    serial_sub_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_sub_ctrl #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_sub_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    // Index 0: WIDTH 8, 1: WIDTH 1, 2: WIDTH 16.
    int          wd [3] = '{8, 1, 16};
    string       nm [3] = '{"w8", "w1", "w16"};
    logic        start_v [3];
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic        bin_v [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic [31:0] diff_v [3];
    logic        bout_v [3];

    assign if8.start  = start_v[0];
    assign if8.a      = a_v[0][7:0];
    assign if8.b      = b_v[0][7:0];
    assign if8.bin    = bin_v[0];
    assign if1.start  = start_v[1];
    assign if1.a      = a_v[1][0:0];
    assign if1.b      = b_v[1][0:0];
    assign if1.bin    = bin_v[1];
    assign if16.start = start_v[2];
    assign if16.a     = a_v[2][15:0];
    assign if16.b     = b_v[2][15:0];
    assign if16.bin   = bin_v[2];

    assign busy_v[0] = if8.busy;
    assign done_v[0] = if8.done;
    assign diff_v[0] = 32'(if8.diff);
    assign bout_v[0] = if8.bout;
    assign busy_v[1] = if1.busy;
    assign done_v[1] = if1.done;
    assign diff_v[1] = 32'(if1.diff);
    assign bout_v[1] = if1.bout;
    assign busy_v[2] = if16.busy;
    assign done_v[2] = if16.done;
    assign diff_v[2] = 32'(if16.diff);
    assign bout_v[2] = if16.bout;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // {borrow, difference} of a - b - bin at width w, by plain integer arithmetic.
    function automatic logic [32:0] ref_sub(input int w, input logic [31:0] av,
                                            input logic [31:0] bv, input logic bi);
        longint m;
        longint r;
        m = (longint'(1) << w) - 1;
        r = (longint'(av) & m) - (longint'(bv) & m) - longint'(bi);
        return {r[w], 32'(r & m)};
    endfunction

    // Model: each accept is remembered by its edge number; busy, done and the
    // result follow from the distance between the current edge and that accept.
    int          edge_n = 0;
    int          acc [3] = '{-1, -1, -1};
    logic [31:0] ma [3];
    logic [31:0] mb [3];
    logic        mbin [3];
    logic [31:0] ediff [3] = '{32'd0, 32'd0, 32'd0};
    logic        ebout [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                acc[i]   = -1;
                ediff[i] = '0;
                ebout[i] = 1'b0;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < 3; i++) begin
                if ((acc[i] < 0 || edge_n >= acc[i] + wd[i] + 2) && start_v[i]) begin
                    acc[i]  = edge_n;
                    ma[i]   = a_v[i];
                    mb[i]   = b_v[i];
                    mbin[i] = bin_v[i];
                end
                if (acc[i] >= 0 && edge_n == acc[i] + wd[i])
                    {ebout[i], ediff[i]} = ref_sub(wd[i], ma[i], mb[i], mbin[i]);
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                logic eb;
                logic ed;
                eb = (acc[i] >= 0) && (edge_n >= acc[i]) && (edge_n < acc[i] + wd[i]);
                ed = (acc[i] >= 0) && (edge_n == acc[i] + wd[i]);
                check({nm[i], "_busy"}, 64'(busy_v[i]), 64'(eb));
                check({nm[i], "_done"}, 64'(done_v[i]), 64'(ed));
                check({nm[i], "_diff"}, 64'(diff_v[i]), 64'(ediff[i]));
                check({nm[i], "_bout"}, 64'(bout_v[i]), 64'(ebout[i]));
                check({nm[i], "_busy_and_done"}, 64'(busy_v[i] & done_v[i]), 64'd0);
            end
        end
    end

    // One operation on instance i; operands are scrambled right after the
    // accepting edge so only the latched values may matter.
    task automatic run_op(input int i, input logic [31:0] av, input logic [31:0] bv,
                          input logic bi, output int busy_cnt);
        bit ok;
        @(negedge clk);
        start_v[i] = 1'b1;
        a_v[i]     = av;
        b_v[i]     = bv;
        bin_v[i]   = bi;
        @(negedge clk);
        start_v[i] = 1'b0;
        a_v[i]     = $urandom;
        b_v[i]     = $urandom;
        bin_v[i]   = 1'($urandom_range(0, 1));
        busy_cnt   = 0;
        ok         = 1'b0;
        for (int k = 0; k < wd[i] + 4; k++) begin
            if (busy_v[i]) busy_cnt++;
            if (done_v[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({nm[i], "_done_timeout"}, 64'(ok), 64'd1);
        @(negedge clk);
    endtask

    localparam logic [7:0] TT_D = 8'b1001_0110;
    localparam logic [7:0] TT_B = 8'b1000_1110;

    initial begin
        int          bc;
        int          done_seen;
        logic        prev_busy;
        int          acc_edges[$];
        logic [7:0]  tt_d;
        logic [7:0]  tt_b;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rbi;
        logic [32:0] exp_r;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
            bin_v[i]   = 1'b0;
        end
        tt_d = TT_D;
        tt_b = TT_B;

        // Pin the model to hand-computed values.
        check("model_5a_3c",    64'(ref_sub(8, 32'h5A, 32'h3C, 1'b0)), 64'h0_0000_001E);
        check("model_00_01",    64'(ref_sub(8, 32'h00, 32'h01, 1'b0)), 64'h1_0000_00FF);
        check("model_ff_00_b1", 64'(ref_sub(8, 32'hFF, 32'h00, 1'b1)), 64'h0_0000_00FE);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        check("reset_busy", 64'(if8.busy), 64'd0);
        check("reset_done", 64'(if8.done), 64'd0);
        check("reset_diff", 64'(if8.diff), 64'd0);
        check("reset_bout", 64'(if8.bout), 64'd0);

        // Directed WIDTH=8 cases.
        run_op(0, 32'h5A, 32'h3C, 1'b0, bc);
        check("basic_diff", 64'(if8.diff), 64'h1E);
        check("basic_bout", 64'(if8.bout), 64'd0);
        check("basic_busy_cycles", 64'(bc), 64'd8);
        run_op(0, 32'h00, 32'h01, 1'b0, bc);
        check("under_diff", 64'(if8.diff), 64'hFF);
        check("under_bout", 64'(if8.bout), 64'd1);
        run_op(0, 32'h10, 32'h10, 1'b1, bc);
        check("eq_bin_diff", 64'(if8.diff), 64'hFF);
        check("eq_bin_bout", 64'(if8.bout), 64'd1);
        run_op(0, 32'hFF, 32'h00, 1'b1, bc);
        check("ff_bin_diff", 64'(if8.diff), 64'hFE);
        check("ff_bin_bout", 64'(if8.bout), 64'd0);

        // start held high: accepts must be WIDTH+2 edges apart.
        @(negedge clk);
        prev_busy  = busy_v[0];
        start_v[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            a_v[0]   = $urandom;
            b_v[0]   = $urandom;
            bin_v[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy_v[0] && !prev_busy) acc_edges.push_back(edge_n);
            prev_busy = busy_v[0];
        end
        start_v[0] = 1'b0;
        check("hold_accept_count", 64'(acc_edges.size()), 64'd3);
        if (acc_edges.size() == 3) begin
            check("hold_gap_1", 64'(acc_edges[1] - acc_edges[0]), 64'd10);
            check("hold_gap_2", 64'(acc_edges[2] - acc_edges[1]), 64'd10);
        end
        repeat (12) @(negedge clk);

        // Asynchronous reset during the 4th RUN cycle.
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 32'h5A;
        b_v[0]     = 32'h3C;
        bin_v[0]   = 1'b0;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(if8.busy), 64'd0);
        check("midrst_done", 64'(if8.done), 64'd0);
        check("midrst_diff", 64'(if8.diff), 64'd0);
        check("midrst_bout", 64'(if8.bout), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        run_op(0, 32'h5A, 32'h3C, 1'b0, bc);
        check("after_rst_diff", 64'(if8.diff), 64'h1E);
        check("after_rst_bout", 64'(if8.bout), 64'd0);

        // WIDTH=1 exhaustive against the full-subtractor truth table.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] abc;
            abc = 3'(v);
            run_op(1, 32'(abc[2]), 32'(abc[1]), abc[0], bc);
            check($sformatf("w1_tt%0d_diff", v), 64'(if1.diff), 64'(tt_d[v]));
            check($sformatf("w1_tt%0d_bout", v), 64'(if1.bout), 64'(tt_b[v]));
            check($sformatf("w1_tt%0d_busy_cycles", v), 64'(bc), 64'd1);
        end

        // WIDTH=16 random regression.
        for (int n = 0; n < 1000; n++) begin
            ra    = 32'($urandom_range(0, 16'hFFFF));
            rb    = 32'($urandom_range(0, 16'hFFFF));
            rbi   = 1'($urandom_range(0, 1));
            exp_r = ref_sub(16, ra, rb, rbi);
            run_op(2, ra, rb, rbi, bc);
            check("w16_rand_result", 64'({if16.bout, if16.diff}), 64'({exp_r[32], exp_r[15:0]}));
        end

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial multi-bit subtractor controller. It sequences a single 1-bit full-subtractor cell (difference = x ^ y ^ c, borrow = (~x & y) | (~(x ^ y) & c)) over WIDTH cycles, LSB first, and carries the borrow between bits in a register. It returns a WIDTH-bit difference and a final borrow. It sits between an operand-issuing master and the full-subtractor datapath, giving area-minimal wide subtraction through a start/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to start an operation; sampled only in IDLE.
- a  input  WIDTH  minuend; latched on the accepting edge.
- b  input  WIDTH  subtrahend; latched on the accepting edge.
- bin  input  1  borrow-in to bit 0; latched on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse while in DONE.
- diff  output  WIDTH  registered result of a − b − bin, modulo 2^WIDTH.
- bout  output  1  registered final borrow; 1 when a < b + bin, unsigned.

## Operation
States:
- IDLE: waits for start.
  - start=1 → latch a, b and bin into shift registers sa, sb and borrow register c; clear the bit counter cnt; go to RUN.
  - start=0 → stay in IDLE.
- RUN: on each edge, feed sa[0], sb[0] and c to the full-subtractor cell.
  - Shift the cell difference into the MSB of the result shift register sd.
  - Shift sa and sb right by 1.
  - Load the cell borrow into c.
  - Increment cnt.
  - When cnt == WIDTH-1 on that edge: load diff ← final sd value (including the current bit), load bout ← cell borrow, go to DONE.
- DONE: on the next edge, go to IDLE unconditionally.

Rules:
- start is ignored in RUN and DONE. No queueing; the master must re-assert start after done.
- a, b and bin may change freely after the accepting edge.
- diff and bout update only on the final RUN edge. They hold their value through IDLE and the following RUN until the next completion.
- cnt width is max(1, $clog2(WIDTH)). It never wraps within an operation.
- WIDTH=1: RUN lasts exactly one edge.
- Unused state encodings → IDLE on the next edge.

## Timing
- Reset (rst_n low, asynchronous, at any time, including mid-RUN):
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - sa, sb, sd, c and cnt are all cleared.
  - An in-flight operation is discarded with no done pulse.
  - Resumes on the first clk edge after rst_n goes high.
- Edge E0 (IDLE, start=1): busy=1 after E0.
- Edges E1..E(WIDTH) process bits 0..WIDTH-1.
- After E(WIDTH): busy=0, done=1, diff and bout valid.
- After E(WIDTH+1): done=0, state=IDLE. The earliest next accept is E(WIDTH+2).
- Latency: WIDTH cycles from the accepting edge to done; WIDTH+2 edges between back-to-back accepts.
- busy and done are never high together. done is exactly one cycle wide.
- Outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Basic subtraction, WIDTH=8: a=0x5A, b=0x3C, bin=0 → done after 8 cycles, diff=0x1E, bout=0. busy is high exactly 8 cycles.
- Underflow and borrow-in, WIDTH=8:
  - a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1.
  - a=0x10, b=0x10, bin=1 → diff=0xFF, bout=1.
  - a=0xFF, b=0x00, bin=1 → diff=0xFE, bout=0.
- Handshake:
  - Hold start=1 continuously → accepts at E0, E10, E20.
  - Change a and b while busy → result reflects the latched values only.
  - diff stays at the old value until each done.
- Reset mid-operation: assert rst_n=0 asynchronously during the 4th RUN cycle → busy, done, diff and bout go to 0 immediately; no done pulse follows. A new start after release gives the correct result (0x5A−0x3C=0x1E).
- WIDTH=1, exhaustive over all 8 (a, b, bin) combinations → diff/bout match the full-subtractor truth table:
  - 000→0/0, 001→1/1, 010→1/1, 011→0/1
  - 100→1/0, 101→0/0, 110→0/0, 111→1/1
  - done follows 1 cycle after each accept.
- Random regression, WIDTH=16: 1000 random (a, b, bin) → {bout, diff} == (a − b − bin) mod 2^17 compared against a reference model. Check that busy and done are never both high.
